// File: rtl/hsc_tdc_top.sv
// rtl/hsc_tdc_top.sv - delay-line TDC: launch select, pulse shaping, tap capture, popcount
// Stages are kept as separate cells so synthesis preserves the physical chain.

module hsc_tdc_stage #(
  parameter string DL_TYPE = "DNAND"
) (
  input  logic en,
  input  logic x,
  output logic y
);
  generate
    if (DL_TYPE == "DNAND") begin : g_dnand
      (* keep = "true", dont_touch = "true" *) logic n1;
      (* keep = "true", dont_touch = "true" *) logic n2;
      assign n1 = ~(en & x);
      assign n2 = ~(en & n1);
      assign y  = n2;
    end else if (DL_TYPE == "BUF") begin : g_buf
      (* keep = "true", dont_touch = "true" *) logic b;
      logic unused_en;
      assign unused_en = en;
      assign b = x;
      assign y = b;
    end else begin : g_bad_type
      $error("hsc_tdc_stage: unsupported DL_TYPE");
    end
  endgenerate
endmodule

module hsc_tdc_top #(
  parameter int    N          = 64,
  parameter string DL_TYPE    = "DNAND",
  parameter int    N_SYNC     = 1,
  parameter string POP_METHOD = "SV",
  parameter int    PG_LEN     = 4
) (
  input  logic                 clk_capture,
  input  logic                 rst,
  input  logic                 clk_launch,
  input  logic                 en,
  input  logic                 val_in,
  input  logic                 pg_src,
  input  logic                 pg_bypass,
  input  logic                 pg_in,
  input  logic                 pg_tog,
  output logic [$clog2(N):0]   hw,
  output logic                 val_out
);
  localparam int HW_W = $clog2(N) + 1;

  generate
    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("hsc_tdc_top: N must be a power of two >= 4");
    end
    if (N_SYNC < 1) begin : g_bad_sync
      $error("hsc_tdc_top: N_SYNC must be >= 1");
    end
    if (PG_LEN < 1) begin : g_bad_pg
      $error("hsc_tdc_top: PG_LEN must be >= 1");
    end
    if (DL_TYPE != "DNAND" && DL_TYPE != "BUF") begin : g_bad_dl
      $error("hsc_tdc_top: DL_TYPE must be DNAND or BUF");
    end
  endgenerate

  logic          src;
  logic          s;
  logic          line_in;
  logic [PG_LEN:0] pg_chain;
  logic [N-1:0]  dl;
  logic [N-1:0]  tap;

  assign src = pg_src ? pg_in : clk_launch;
  assign s   = src ^ pg_tog;

  // Pulse width is the propagation time of the internal chain; in zero-delay sim it collapses to 0.
  assign pg_chain[0] = s;
  generate
    for (genvar p = 0; p < PG_LEN; p++) begin : g_pg
      hsc_tdc_stage #(.DL_TYPE(DL_TYPE)) u_pg_stage (
        .en (1'b1),
        .x  (pg_chain[p]),
        .y  (pg_chain[p+1])
      );
    end
  endgenerate

  assign line_in = pg_bypass ? s : (s & ~pg_chain[PG_LEN]);

  generate
    for (genvar i = 0; i < N; i++) begin : g_dl
      if (i == 0) begin : g_first
        hsc_tdc_stage #(.DL_TYPE(DL_TYPE)) u_stage (
          .en (en),
          .x  (line_in & en),
          .y  (dl[0])
        );
      end else begin : g_rest
        hsc_tdc_stage #(.DL_TYPE(DL_TYPE)) u_stage (
          .en (en),
          .x  (dl[i-1]),
          .y  (dl[i])
        );
      end
    end
  endgenerate

  // A disabled DNAND stage drives 1; qualifying with en forces idle taps to 0 uniformly.
  assign tap = dl & {N{en}};

  logic [N-1:0]      sync_q [N_SYNC];
  logic [N_SYNC-1:0] val_q;
  logic [N-1:0]      last;
  logic [HW_W-1:0]   pop;

  assign last = sync_q[N_SYNC-1];

  generate
    if (POP_METHOD == "SV") begin : g_pop_sv
      always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
          pop = pop + HW_W'(last[i]);
        end
      end
    end else if (POP_METHOD == "TREE") begin : g_pop_tree
      // Heap-ordered tree: node k sums children 2k and 2k+1; leaves sit at N..2N-1.
      logic [HW_W-1:0] node [1:2*N-1];
      for (genvar i = 0; i < N; i++) begin : g_leaf
        assign node[N+i] = HW_W'(last[i]);
      end
      for (genvar k = 1; k < N; k++) begin : g_sum
        assign node[k] = node[2*k] + node[2*k+1];
      end
      assign pop = node[1];
    end else begin : g_bad_pop
      $error("hsc_tdc_top: POP_METHOD must be SV or TREE");
    end
  endgenerate

  always_ff @(posedge clk_capture or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SYNC; k++) begin
        sync_q[k] <= '0;
      end
      val_q   <= '0;
      hw      <= '0;
      val_out <= 1'b0;
    end else if (en) begin
      sync_q[0] <= tap;
      val_q[0]  <= val_in;
      for (int k = 1; k < N_SYNC; k++) begin
        sync_q[k] <= sync_q[k-1];
        val_q[k]  <= val_q[k-1];
      end
      hw      <= pop;
      val_out <= val_q[N_SYNC-1];
    end
  end
endmodule

// File: tb/tb_hsc_tdc_top.sv
// tb/tb_hsc_tdc_top.sv - directed bench for hsc_tdc_top, SV and TREE popcount side by side

module tb_hsc_tdc_top;
  logic       clk_capture;
  logic       rst;
  logic       clk_launch;
  logic       en;
  logic       val_in;
  logic       pg_src;
  logic       pg_bypass;
  logic       pg_in;
  logic       pg_tog;
  logic [6:0] hw_sv;
  logic       val_sv;
  logic [6:0] hw_tr;
  logic       val_tr;

  int vecs = 0;
  int errs = 0;

  hsc_tdc_top #(.N(64), .DL_TYPE("DNAND"), .N_SYNC(1), .POP_METHOD("SV"), .PG_LEN(4)) u_dut_sv (
    .clk_capture (clk_capture),
    .rst         (rst),
    .clk_launch  (clk_launch),
    .en          (en),
    .val_in      (val_in),
    .pg_src      (pg_src),
    .pg_bypass   (pg_bypass),
    .pg_in       (pg_in),
    .pg_tog      (pg_tog),
    .hw          (hw_sv),
    .val_out     (val_sv)
  );

  hsc_tdc_top #(.N(64), .DL_TYPE("BUF"), .N_SYNC(1), .POP_METHOD("TREE"), .PG_LEN(4)) u_dut_tree (
    .clk_capture (clk_capture),
    .rst         (rst),
    .clk_launch  (clk_launch),
    .en          (en),
    .val_in      (val_in),
    .pg_src      (pg_src),
    .pg_bypass   (pg_bypass),
    .pg_in       (pg_in),
    .pg_tog      (pg_tog),
    .hw          (hw_tr),
    .val_out     (val_tr)
  );

  initial clk_capture = 1'b0;
  always #5 clk_capture = ~clk_capture;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input int exp_hw, input int exp_val);
    chk({tag, " hw sv"},    32'(hw_sv),  32'(exp_hw));
    chk({tag, " val sv"},   32'(val_sv), 32'(exp_val));
    chk({tag, " hw tree"},  32'(hw_tr),  32'(exp_hw));
    chk({tag, " val tree"}, 32'(val_tr), 32'(exp_val));
  endtask

  task automatic tick();
    @(posedge clk_capture);
    #1;
  endtask

  int vin_seq [6] = '{1, 0, 1, 1, 0, 0};
  int lau_seq [6] = '{1, 0, 0, 1, 1, 0};

  initial begin
    rst = 1'b0; clk_launch = 1'b0; en = 1'b0; val_in = 1'b0;
    pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b0; pg_tog = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk_both("reset state", 0, 0);
    tick();
    tick();
    rst = 1'b0;

    en = 1'b1; clk_launch = 1'b1; val_in = 1'b1;
    tick();
    chk_both("launch edge1", 0, 0);
    tick();
    chk_both("launch edge2", 64, 1);

    #3 rst = 1'b1;
    #1;
    chk_both("async reset", 0, 0);
    #1 rst = 1'b0;
    tick();
    chk_both("post reset edge1", 0, 0);
    tick();
    chk_both("post reset edge2", 64, 1);

    pg_tog = 1'b1;
    tick();
    tick();
    chk_both("tog inverts", 0, 1);

    pg_src = 1'b1; pg_in = 1'b0;
    tick();
    chk_both("pg_in edge1", 0, 1);
    tick();
    chk_both("pg_in edge2", 64, 1);

    pg_bypass = 1'b0;
    tick();
    tick();
    chk_both("shaper pg_in", 0, 1);
    pg_src = 1'b0; pg_tog = 1'b0; clk_launch = 1'b1;
    tick();
    tick();
    chk_both("shaper launch", 0, 1);

    pg_bypass = 1'b1;
    tick();
    tick();
    chk_both("restore 64", 64, 1);

    en = 1'b0; clk_launch = 1'b0; val_in = 1'b0;
    repeat (5) tick();
    chk_both("hold disabled", 64, 1);
    en = 1'b1;
    tick();
    chk_both("reenable edge1", 64, 1);
    tick();
    chk_both("reenable edge2", 0, 0);

    for (int j = 0; j < 6; j++) begin
      val_in     = vin_seq[j][0];
      clk_launch = lau_seq[j][0];
      tick();
      chk_both($sformatf("seq step%0d", j),
               (j == 0) ? 0 : lau_seq[j-1] * 64,
               (j == 0) ? 0 : vin_seq[j-1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hsc_tdc_top.md
Name: hsc_tdc_top

Overview:
- Top of a delay-line time-to-digital converter (TDC).
- A selectable launch source passes through an optional pulse generator into an N-stage delay line.
- All N delay-line taps are sampled on the capture clock, pass through N_SYNC synchronizer stages, and are reduced to a registered population count (Hamming weight).
- A valid flag travels alongside the data with identical latency.
- Sits under the chip pin-mapping wrapper; hw and val_out drive the dedicated outputs.

Parameters:
- N, 64: number of delay-line stages/taps; power of two, at least 4.
- DL_TYPE, "DNAND": stage type. "DNAND" = two cascaded 2-input NANDs, second input tied to en. "BUF" = non-inverting buffer. Any other value is an elaboration error.
- N_SYNC, 1: number of tap register stages, at least 1. The first stage is the capture stage.
- POP_METHOD, "SV": popcount implementation. "SV" = behavioural loop. "TREE" = explicit pairwise adder tree. Results are bit-identical.
- PG_LEN, 4: stage count of the pulse-generator internal delay chain, at least 1.

Ports:
- clk_capture  in  1  sole clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_launch  in  1  launch signal. Treated as data feeding the delay line; never clocks a flop.
- en  in  1  enable; gates the delay line and the pipeline.
- val_in  in  1  sample-valid tag.
- pg_src  in  1  source select: 0 = clk_launch, 1 = pg_in.
- pg_bypass  in  1  1 = skip pulse shaping.
- pg_in  in  1  alternate launch source.
- pg_tog  in  1  inverts the selected source (selects which edge is measured).
- hw  out  $clog2(N)+1  Hamming weight of the captured taps, range 0..N.
- val_out  out  1  val_in delayed to align with hw.

Behaviour:
- Source path: src = pg_src ? pg_in : clk_launch; s = src XOR pg_tog.
- Pulse generator output:
  - pg_bypass=1: line_in = s.
  - pg_bypass=0: line_in = s AND NOT(s through PG_LEN stages of type DL_TYPE).
  - Purely combinational.
  - In zero-delay RTL simulation the non-bypass output is constant 0.
- Delay line:
  - tap[0] = stage0(line_in AND en); tap[i] = stage_i(tap[i-1]).
  - Each stage is non-inverting. For DNAND: nand(en, nand(en, x)).
  - With en=0 all taps are 0.
  - Stages must carry synthesis keep/dont_touch attributes so they are not optimised away.
- Pipeline, on clk_capture rising edge when en=1:
  - sync[0] <= tap; sync[k] <= sync[k-1] for k = 1..N_SYNC-1.
  - hw <= popcount(sync[N_SYNC-1]).
  - A val_in shift chain of the same depth feeds val_out.
- en=0: every register holds its value.
- Latency: N_SYNC+1 enabled edges from tap/val_in sampling to hw/val_out. This is 2 for the defaults.
- Width rule: hw is $clog2(N)+1 bits so that value N is representable (N=64 gives 7 bits, max 7'b1000000). No saturation or wrap.
- Reset: all sync stages, the val chain, hw and val_out go to 0 immediately on rst=1, independent of the clock. They hold 0 while rst=1.
- Reset mid-operation: in-flight samples are discarded. After rst falls, the first valid hw appears N_SYNC+1 enabled edges later.
- Simultaneous rst and clock edge: reset wins.
- Outputs change only on clk_capture edges or on rst.

Test Plan:
- rst=1 pulse asynchronously mid-cycle -> hw=0 and val_out=0 immediately, with no clock edge needed.
- en=1, pg_bypass=1, pg_src=0, pg_tog=0, clk_launch=1, val_in=1 -> after 2 edges hw=64, val_out=1. After 1 edge hw is still 0.
- Same setup with pg_tog=1 -> hw=0. Then pg_src=1, pg_in=0 -> hw=64 two edges later.
- pg_bypass=0 with any static source -> hw=0.
- en=0 after hw=64, then drive clk_launch=0 and toggle the clock 5 times -> hw stays 64 and val_out holds. Re-enable -> hw=0 after 2 edges.
- Toggle val_in 1,0,1,1 on successive edges with en=1 -> val_out reproduces 1,0,1,1 shifted by exactly 2 edges. Repeat with POP_METHOD="TREE" -> identical hw/val_out trace.
